// File: rtl/pl_cpu.sv
// pl_cpu: 5-stage in-order RV32I pipeline (IF, ID, EX, MEM, WB).
//
// Ports (top):
//   clk  - single system clock, all state updates on the rising edge
//   rst  - asynchronous active-low reset
//
// Sub-blocks (instance names are stable so programs and state can be
// reached hierarchically):
//   instruction_mem - word-addressed instruction ROM, mem[0:INSTR_MEM_DEPTH-1]
//   data_mem        - word-addressed data RAM, comb read / clocked write
//   rf              - 32 x 32-bit register file, regs[0:31], write-through
//
// Hazards: EX operands are forwarded from EX/MEM then MEM/WB; a load
// followed by a dependent instruction stalls IF/ID one cycle; branches and
// jumps resolve in EX and flush IF/ID and ID/EX. Flush wins over stall.

// Instruction memory. Asynchronous read of word raddr_i modulo DEPTH.
// The load port lets contents be placed without a file-based preload; the
// core ties it off so reset never touches the program.
module pl_cpu_imem #(
    parameter int DEPTH = 1024
) (
    input  logic        clk,
    input  logic        we_i,
    input  logic [29:0] waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [29:0] raddr_i,
    output logic [31:0] rdata_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [31:0] mem [0:DEPTH-1];
    logic [29:0] rmod;
    logic [29:0] wmod;

    assign rmod    = raddr_i % 30'(DEPTH);
    assign wmod    = waddr_i % 30'(DEPTH);
    assign rdata_o = mem[rmod[AW-1:0]];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[wmod[AW-1:0]] <= wdata_i;
        end
    end
endmodule

// Data memory. Word address modulo DEPTH; combinational read, write on
// the rising edge. Contents are deliberately not reset.
module pl_cpu_dmem #(
    parameter int DEPTH = 1024
) (
    input  logic        clk,
    input  logic        we_i,
    input  logic [29:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [31:0] mem [0:DEPTH-1];
    logic [29:0] amod;

    assign amod    = addr_i % 30'(DEPTH);
    assign rdata_o = mem[amod[AW-1:0]];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[amod[AW-1:0]] <= wdata_i;
        end
    end
endmodule

// Register file: two read ports, one write port. x0 reads as zero and
// ignores writes. A read of the register being written this cycle returns
// the incoming value, so WB-to-ID needs no separate forwarding path.
module pl_cpu_rf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  raddr1_i,
    output logic [31:0] rdata1_o,
    input  logic [4:0]  raddr2_i,
    output logic [31:0] rdata2_o,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i
);
    logic [31:0] regs [0:31];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (we_i && (waddr_i != 5'd0)) begin
            regs[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        rdata1_o = regs[raddr1_i];
        rdata2_o = regs[raddr2_i];
        if (we_i && (waddr_i == raddr1_i)) rdata1_o = wdata_i;
        if (we_i && (waddr_i == raddr2_i)) rdata2_o = wdata_i;
        if (raddr1_i == 5'd0) rdata1_o = '0;
        if (raddr2_i == 5'd0) rdata2_o = '0;
    end
endmodule

module pl_cpu #(
    parameter int          INSTR_MEM_DEPTH = 1024,
    parameter int          DATA_MEM_DEPTH  = 1024,
    parameter logic [31:0] MAX_INSTR_ADDR  = 32'h48
) (
    input logic clk,
    input logic rst
);
    localparam logic [31:0] NOP = 32'h0000_0013;  // addi x0,x0,0

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
        ALU_SLT, ALU_SLL, ALU_SRL, ALU_SRA
    } alu_op_e;

    typedef struct packed {
        logic    reg_we;
        logic    mem_re;
        logic    mem_we;
        logic    use_imm;
        logic    is_branch;
        logic    br_ne;
        logic    is_jal;
        logic    is_jalr;
        alu_op_e alu_op;
    } ctrl_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ifid_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        ctrl_t       ctrl;
    } idex_t;

    typedef struct packed {
        logic [31:0] result;
        logic [31:0] store_data;
        logic [4:0]  rd;
        logic        reg_we;
        logic        mem_re;
        logic        mem_we;
    } exmem_t;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        reg_we;
    } memwb_t;

    localparam ifid_t IFID_RST = '{pc: 32'd0, instr: NOP};

    logic [31:0] pc_q, pc_d;
    ifid_t       ifid_q, ifid_d;
    idex_t       idex_q, idex_d;
    exmem_t      exmem_q, exmem_d;
    memwb_t      memwb_q, memwb_d;

    // ---------------------------------------------------------------- IF
    logic [31:0] imem_rdata;
    logic [31:0] if_instr;
    logic        fetch_done;

    pl_cpu_imem #(.DEPTH(INSTR_MEM_DEPTH)) instruction_mem (
        .clk     (clk),
        .we_i    (1'b0),
        .waddr_i (30'd0),
        .wdata_i (32'd0),
        .raddr_i (pc_q[31:2]),
        .rdata_o (imem_rdata)
    );

    // Past the end of the program: feed NOPs and let the pipe drain.
    assign fetch_done = (pc_q > MAX_INSTR_ADDR);
    assign if_instr   = fetch_done ? NOP : imem_rdata;

    // ---------------------------------------------------------------- ID
    logic [31:0] id_instr;
    logic [6:0]  id_opcode;
    logic [2:0]  id_f3;
    logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [31:0] id_imm;
    ctrl_t       id_ctrl;
    logic        id_legal;
    logic [31:0] rf_rdata1, rf_rdata2;

    assign id_instr  = ifid_q.instr;
    assign id_opcode = id_instr[6:0];
    assign id_f3     = id_instr[14:12];
    assign imm_i = {{20{id_instr[31]}}, id_instr[31:20]};
    assign imm_s = {{20{id_instr[31]}}, id_instr[31:25], id_instr[11:7]};
    assign imm_b = {{19{id_instr[31]}}, id_instr[31], id_instr[7],
                    id_instr[30:25], id_instr[11:8], 1'b0};
    assign imm_j = {{11{id_instr[31]}}, id_instr[31], id_instr[19:12],
                    id_instr[20], id_instr[30:21], 1'b0};
    assign imm_u = {id_instr[31:12], 12'd0};

    // Register indices are only reported when the instruction really reads
    // them, so immediate bits never trigger false hazards.
    always_comb begin
        id_ctrl  = '0;
        id_rs1   = '0;
        id_rs2   = '0;
        id_rd    = '0;
        id_imm   = '0;
        id_legal = 1'b1;
        case (id_opcode)
            OP_R, OP_IMM: begin
                id_rs1         = id_instr[19:15];
                id_rd          = id_instr[11:7];
                id_ctrl.reg_we = 1'b1;
                if (id_opcode == OP_R) begin
                    id_rs2 = id_instr[24:20];
                end else begin
                    id_imm          = imm_i;
                    id_ctrl.use_imm = 1'b1;
                end
                case (id_f3)
                    3'b000: id_ctrl.alu_op = (id_opcode == OP_R && id_instr[30])
                                             ? ALU_SUB : ALU_ADD;
                    3'b001: id_ctrl.alu_op = ALU_SLL;
                    3'b010: id_ctrl.alu_op = ALU_SLT;
                    3'b100: id_ctrl.alu_op = ALU_XOR;
                    3'b101: id_ctrl.alu_op = id_instr[30] ? ALU_SRA : ALU_SRL;
                    3'b110: id_ctrl.alu_op = ALU_OR;
                    3'b111: id_ctrl.alu_op = ALU_AND;
                    default: id_legal = 1'b0;  // sltu/sltiu
                endcase
            end
            OP_LUI: begin
                id_rd           = id_instr[11:7];
                id_imm          = imm_u;
                id_ctrl.reg_we  = 1'b1;
                id_ctrl.use_imm = 1'b1;
            end
            OP_LOAD: begin
                id_rs1          = id_instr[19:15];
                id_rd           = id_instr[11:7];
                id_imm          = imm_i;
                id_ctrl.reg_we  = 1'b1;
                id_ctrl.mem_re  = 1'b1;
                id_ctrl.use_imm = 1'b1;
                id_legal        = (id_f3 == 3'b010);
            end
            OP_STORE: begin
                id_rs1          = id_instr[19:15];
                id_rs2          = id_instr[24:20];
                id_imm          = imm_s;
                id_ctrl.mem_we  = 1'b1;
                id_ctrl.use_imm = 1'b1;
                id_legal        = (id_f3 == 3'b010);
            end
            OP_BRANCH: begin
                id_rs1            = id_instr[19:15];
                id_rs2            = id_instr[24:20];
                id_imm            = imm_b;
                id_ctrl.is_branch = 1'b1;
                id_ctrl.br_ne     = id_f3[0];
                id_legal          = (id_f3[2:1] == 2'b00);
            end
            OP_JAL: begin
                id_rd          = id_instr[11:7];
                id_imm         = imm_j;
                id_ctrl.reg_we = 1'b1;
                id_ctrl.is_jal = 1'b1;
            end
            OP_JALR: begin
                id_rs1          = id_instr[19:15];
                id_rd           = id_instr[11:7];
                id_imm          = imm_i;
                id_ctrl.reg_we  = 1'b1;
                id_ctrl.is_jalr = 1'b1;
                id_legal        = (id_f3 == 3'b000);
            end
            default: id_legal = 1'b0;
        endcase
        if (!id_legal) begin
            id_ctrl = '0;
            id_rs1  = '0;
            id_rs2  = '0;
            id_rd   = '0;
            id_imm  = '0;
        end
    end

    pl_cpu_rf rf (
        .clk      (clk),
        .rst_n    (rst),
        .raddr1_i (id_rs1),
        .rdata1_o (rf_rdata1),
        .raddr2_i (id_rs2),
        .rdata2_o (rf_rdata2),
        .we_i     (memwb_q.reg_we),
        .waddr_i  (memwb_q.rd),
        .wdata_i  (memwb_q.data)
    );

    // Load result is not available until MEM, so a consumer right behind
    // a load must wait one cycle.
    logic load_use;
    assign load_use = idex_q.ctrl.mem_re && (idex_q.rd != 5'd0) &&
                      ((idex_q.rd == id_rs1) || (idex_q.rd == id_rs2));

    // ---------------------------------------------------------------- EX
    logic [31:0] fwd_a, fwd_b, alu_b, alu_y, ex_result, ex_target;
    logic        br_taken, redirect, stall;

    always_comb begin
        fwd_a = idex_q.rs1_val;
        fwd_b = idex_q.rs2_val;
        if (memwb_q.reg_we && memwb_q.rd != 5'd0 && memwb_q.rd == idex_q.rs1) fwd_a = memwb_q.data;
        if (memwb_q.reg_we && memwb_q.rd != 5'd0 && memwb_q.rd == idex_q.rs2) fwd_b = memwb_q.data;
        // EX/MEM is the younger producer, so it overrides MEM/WB.
        if (exmem_q.reg_we && exmem_q.rd != 5'd0 && exmem_q.rd == idex_q.rs1) fwd_a = exmem_q.result;
        if (exmem_q.reg_we && exmem_q.rd != 5'd0 && exmem_q.rd == idex_q.rs2) fwd_b = exmem_q.result;
    end

    assign alu_b = idex_q.ctrl.use_imm ? idex_q.imm : fwd_b;

    always_comb begin
        alu_y = '0;
        case (idex_q.ctrl.alu_op)
            ALU_ADD: alu_y = fwd_a + alu_b;
            ALU_SUB: alu_y = fwd_a - alu_b;
            ALU_AND: alu_y = fwd_a & alu_b;
            ALU_OR:  alu_y = fwd_a | alu_b;
            ALU_XOR: alu_y = fwd_a ^ alu_b;
            ALU_SLT: alu_y = {31'd0, $signed(fwd_a) < $signed(alu_b)};
            ALU_SLL: alu_y = fwd_a << alu_b[4:0];
            ALU_SRL: alu_y = fwd_a >> alu_b[4:0];
            ALU_SRA: alu_y = $unsigned($signed(fwd_a) >>> alu_b[4:0]);
            default: alu_y = fwd_a + alu_b;
        endcase
    end

    assign br_taken  = idex_q.ctrl.is_branch && ((fwd_a == fwd_b) != idex_q.ctrl.br_ne);
    assign redirect  = br_taken || idex_q.ctrl.is_jal || idex_q.ctrl.is_jalr;
    assign ex_target = idex_q.ctrl.is_jalr ? ((fwd_a + idex_q.imm) & ~32'd1)
                                           : (idex_q.pc + idex_q.imm);
    assign ex_result = (idex_q.ctrl.is_jal || idex_q.ctrl.is_jalr) ? (idex_q.pc + 32'd4)
                                                                   : alu_y;
    // A redirect discards the instruction that would have stalled.
    assign stall = load_use && !redirect;

    // --------------------------------------------------------------- MEM
    logic [31:0] dmem_rdata;

    pl_cpu_dmem #(.DEPTH(DATA_MEM_DEPTH)) data_mem (
        .clk     (clk),
        .we_i    (exmem_q.mem_we),
        .addr_i  (exmem_q.result[31:2]),
        .wdata_i (exmem_q.store_data),
        .rdata_o (dmem_rdata)
    );

    // -------------------------------------------------------- next state
    always_comb begin
        pc_d   = pc_q;
        ifid_d = ifid_q;
        if (redirect) begin
            pc_d   = ex_target;
            ifid_d = IFID_RST;
        end else if (!stall) begin
            ifid_d = '{pc: pc_q, instr: if_instr};
            if (!fetch_done) pc_d = pc_q + 32'd4;
        end

        idex_d = '0;
        if (!redirect && !stall) begin
            idex_d.pc      = ifid_q.pc;
            idex_d.rs1_val = rf_rdata1;
            idex_d.rs2_val = rf_rdata2;
            idex_d.imm     = id_imm;
            idex_d.rs1     = id_rs1;
            idex_d.rs2     = id_rs2;
            idex_d.rd      = id_rd;
            idex_d.ctrl    = id_ctrl;
        end

        exmem_d.result     = ex_result;
        exmem_d.store_data = fwd_b;
        exmem_d.rd         = idex_q.rd;
        exmem_d.reg_we     = idex_q.ctrl.reg_we;
        exmem_d.mem_re     = idex_q.ctrl.mem_re;
        exmem_d.mem_we     = idex_q.ctrl.mem_we;

        memwb_d.data   = exmem_q.mem_re ? dmem_rdata : exmem_q.result;
        memwb_d.rd     = exmem_q.rd;
        memwb_d.reg_we = exmem_q.reg_we;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q    <= '0;
            ifid_q  <= IFID_RST;
            idex_q  <= '0;
            exmem_q <= '0;
            memwb_q <= '0;
        end else begin
            pc_q    <= pc_d;
            ifid_q  <= ifid_d;
            idex_q  <= idex_d;
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
        end
    end
endmodule

// File: tb/tb_pl_cpu.sv
// Directed testbench for pl_cpu: loads small RV32I programs into the
// instruction memory, runs them, and compares architectural state against
// hand-computed results.
module tb_pl_cpu;
    logic clk = 1'b0;
    logic rst = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] prog [0:18];

    pl_cpu #(
        .INSTR_MEM_DEPTH (1024),
        .DATA_MEM_DEPTH  (1024),
        .MAX_INSTR_ADDR  (32'h48)
    ) dut (
        .clk (clk),
        .rst (rst)
    );

    always #5 clk = ~clk;

    // ---------------------------------------------------------- assembler
    function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3,
                                          input int rd, input logic [6:0] op);
        logic [11:0] im;
        im = imm[11:0];
        return {im, rs1[4:0], f3[2:0], rd[4:0], op};
    endfunction

    function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1,
                                          input int f3, input int rd);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
    endfunction

    function automatic logic [31:0] enc_s(input int off, input int rs2, input int rs1);
        logic [11:0] im;
        im = off[11:0];
        return {im[11:5], rs2[4:0], rs1[4:0], 3'b010, im[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] enc_b(input int off, input int rs2, input int rs1,
                                          input int f3);
        logic [12:0] im;
        im = off[12:0];
        return {im[12], im[10:5], rs2[4:0], rs1[4:0], f3[2:0], im[4:1], im[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_j(input int off, input int rd);
        logic [20:0] im;
        im = off[20:0];
        return {im[20], im[10:1], im[11], im[19:12], rd[4:0], 7'h6F};
    endfunction

    function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
        return enc_i(imm, rs1, 0, rd, 7'h13);
    endfunction

    // ------------------------------------------------------------ drivers
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_prog();
        for (int i = 0; i < 19; i++) begin
            dut.instruction_mem.mem[i] = prog[i];
        end
    endtask

    // Waits (sampling on falling edges) until the PC equals target; edges
    // reports the number of rising edges taken, or -1 if the budget ran out.
    task automatic run_until_pc(input logic [31:0] target, input int budget,
                                output int edges);
        edges = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (dut.pc_q == target) begin
                edges = i;
                break;
            end
        end
    endtask

    // ---------------------------------------------------------- checking
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_prog_b(input string p);
        check({p, "_pc_hold"}, dut.pc_q, 32'h4C);
        check({p, "_x5"},  dut.rf.regs[5],  32'd0);
        check({p, "_x6"},  dut.rf.regs[6],  32'd3);
        check({p, "_x1"},  dut.rf.regs[1],  32'h14);
        check({p, "_x7"},  dut.rf.regs[7],  32'd9);
        check({p, "_x21"}, dut.rf.regs[21], 32'd1);
        check({p, "_x22"}, dut.rf.regs[22], 32'd0);
        check({p, "_x23"}, dut.rf.regs[23], 32'd0);
        check({p, "_x24"}, dut.rf.regs[24], 32'd7);
        check({p, "_x25"}, dut.rf.regs[25], 32'd5);
        check({p, "_x26"}, dut.rf.regs[26], 32'd0);
        check({p, "_x27"}, dut.rf.regs[27], 32'd2);
        check({p, "_x28"}, dut.rf.regs[28], 32'd3);
        check({p, "_x31"}, dut.rf.regs[31], 32'd0);
    endtask

    // ---------------------------------------------------------- programs
    task automatic build_prog_a();
        prog[0]  = addi(1, 0, 5);                  // 0x00 x1=5
        prog[1]  = addi(2, 1, 3);                  // 0x04 x2=8
        prog[2]  = enc_s(0, 2, 0);                 // 0x08 sw x2,0(x0)
        prog[3]  = enc_i(0, 0, 2, 3, 7'h03);       // 0x0C lw x3,0(x0)
        prog[4]  = enc_r(0, 3, 3, 0, 4);           // 0x10 add x4,x3,x3
        prog[5]  = enc_r(32, 2, 1, 0, 8);          // 0x14 sub x8,x1,x2
        prog[6]  = enc_r(0, 1, 8, 2, 9);           // 0x18 slt x9,x8,x1
        prog[7]  = enc_r(32, 9, 8, 5, 10);         // 0x1C sra x10,x8,x9
        prog[8]  = enc_r(0, 9, 8, 5, 11);          // 0x20 srl x11,x8,x9
        prog[9]  = {20'h12345, 5'd12, 7'h37};      // 0x24 lui x12,0x12345
        prog[10] = enc_i(-1, 12, 4, 13, 7'h13);    // 0x28 xori x13,x12,-1
        prog[11] = enc_r(0, 1, 1, 1, 14);          // 0x2C sll x14,x1,x1
        prog[12] = enc_r(0, 12, 13, 7, 15);        // 0x30 and x15,x13,x12
        prog[13] = enc_r(0, 12, 13, 6, 16);        // 0x34 or x16,x13,x12
        prog[14] = enc_i(-4, 8, 2, 17, 7'h13);     // 0x38 slti x17,x8,-4
        prog[15] = enc_i(28, 16, 5, 18, 7'h13);    // 0x3C srli x18,x16,28
        prog[16] = enc_i(32'hF0, 16, 7, 19, 7'h13);// 0x40 andi x19,x16,0xF0
        prog[17] = enc_i(32'h123, 0, 6, 20, 7'h13);// 0x44 ori x20,x0,0x123
        prog[18] = enc_s(4, 4, 0);                 // 0x48 sw x4,4(x0)
    endtask

    task automatic build_prog_b();
        prog[0]  = addi(5, 0, 3);                  // 0x00
        prog[1]  = addi(5, 5, -1);                 // 0x04 L:
        prog[2]  = addi(6, 6, 1);                  // 0x08
        prog[3]  = enc_b(-8, 0, 5, 1);             // 0x0C bne x5,x0,L
        prog[4]  = enc_j(16, 1);                   // 0x10 jal x1,F(0x20)
        prog[5]  = addi(21, 21, 1);                // 0x14 resume point
        prog[6]  = enc_j(20, 0);                   // 0x18 jal x0,0x2C
        prog[7]  = addi(22, 0, 1);                 // 0x1C never retires
        prog[8]  = addi(7, 0, 9);                  // 0x20 F:
        prog[9]  = enc_i(0, 1, 0, 0, 7'h67);       // 0x24 jalr x0,0(x1)
        prog[10] = addi(23, 0, 1);                 // 0x28 never retires
        prog[11] = 32'hFFFF_FFFF;                  // 0x2C unsupported opcode
        prog[12] = addi(24, 0, 7);                 // 0x30
        prog[13] = enc_b(8, 6, 5, 0);              // 0x34 beq x5,x6 (not taken)
        prog[14] = addi(25, 0, 5);                 // 0x38
        prog[15] = enc_b(8, 0, 5, 0);              // 0x3C beq x5,x0 -> 0x44
        prog[16] = addi(26, 0, 1);                 // 0x40 skipped
        prog[17] = addi(27, 0, 2);                 // 0x44
        prog[18] = addi(28, 27, 1);                // 0x48
    endtask

    // --------------------------------------------------------------- main
    initial begin
        int edges;

        // Reset state with program A loaded.
        rst = 1'b0;
        build_prog_a();
        load_prog();
        tick(3);
        check("rst_pc", dut.pc_q, 32'd0);
        check("rst_x1", dut.rf.regs[1], 32'd0);
        check("rst_x31", dut.rf.regs[31], 32'd0);

        // Program A: forwarding, one load-use stall, ALU coverage.
        rst = 1'b1;
        run_until_pc(32'h4C, 100, edges);
        check("a_edges_to_end", 32'(edges), 32'd20);
        tick(10);
        check("a_pc_hold", dut.pc_q, 32'h4C);
        check("a_x2_fwd", dut.rf.regs[2], 32'd8);
        check("a_mem0", dut.data_mem.mem[0], 32'd8);
        check("a_x3_lw", dut.rf.regs[3], 32'd8);
        check("a_x4_loaduse", dut.rf.regs[4], 32'd16);
        check("a_x8_sub", dut.rf.regs[8], 32'hFFFF_FFFD);
        check("a_x9_slt", dut.rf.regs[9], 32'd1);
        check("a_x10_sra", dut.rf.regs[10], 32'hFFFF_FFFE);
        check("a_x11_srl", dut.rf.regs[11], 32'h7FFF_FFFE);
        check("a_x12_lui", dut.rf.regs[12], 32'h1234_5000);
        check("a_x13_xori", dut.rf.regs[13], 32'hEDCB_AFFF);
        check("a_x14_sll", dut.rf.regs[14], 32'h0000_00A0);
        check("a_x15_and", dut.rf.regs[15], 32'd0);
        check("a_x16_or", dut.rf.regs[16], 32'hFFFF_FFFF);
        check("a_x17_slti", dut.rf.regs[17], 32'd0);
        check("a_x18_srli", dut.rf.regs[18], 32'hF);
        check("a_x19_andi", dut.rf.regs[19], 32'hF0);
        check("a_x20_ori", dut.rf.regs[20], 32'h123);
        check("a_mem1", dut.data_mem.mem[1], 32'd16);
        check("a_x21_untouched", dut.rf.regs[21], 32'd0);

        // Program B: loop, jal/jalr, flushes, unsupported opcode.
        rst = 1'b0;
        tick(2);
        build_prog_b();
        load_prog();
        check("b_rst_x4", dut.rf.regs[4], 32'd0);
        rst = 1'b1;
        tick(1);
        check("b_first_fetch_pc", dut.pc_q, 32'd4);
        run_until_pc(32'h4C, 200, edges);
        check("b_reached_end", 32'(edges > 0), 32'd1);
        tick(10);
        check_prog_b("b");
        check("b_mem0_kept", dut.data_mem.mem[0], 32'd8);

        // Reset pulsed mid-program, then full re-run.
        rst = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(12);
        rst = 1'b0;
        tick(1);
        check("mid_rst_pc", dut.pc_q, 32'd0);
        check("mid_rst_x5", dut.rf.regs[5], 32'd0);
        check("mid_rst_x6", dut.rf.regs[6], 32'd0);
        tick(1);
        rst = 1'b1;
        tick(1);
        check("mid_first_fetch_pc", dut.pc_q, 32'd4);
        run_until_pc(32'h4C, 200, edges);
        check("r_reached_end", 32'(edges > 0), 32'd1);
        tick(10);
        check_prog_b("r");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
